axi_burst_slave_mem: RTL and testbench

- AXI4 (full) burst slave backed by an internal register-array memory.
- Sits directly downstream of the axi_master M00_AXI port, replacing the VIP slave so the master's write/read-verify sequence runs in synthesizable form (self-test BD, on-board loopback).
- Independent write and read FSMs; one outstanding transaction per direction.

---
 rtl/axi_burst_slave_mem.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_burst_slave_mem.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_slave_mem.sv
// AXI4 burst slave backed by an internal word array; independent write and read FSMs.
// Build macro AXI_SLV_RANGE_CHECK_EN: beats beyond the array get SLVERR instead of wrapping.
module axi_burst_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS    = 1024
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic [1:0]                        s00_axi_awburst,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic [1:0]                        s00_axi_arburst,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);
  localparam int WA = C_S_AXI_ADDR_WIDTH - 2;
  localparam int IW = $clog2(MEM_DEPTH_WORDS);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IDW = C_S_AXI_ID_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DW-1:0] mem_q [MEM_DEPTH_WORDS];

  w_state_e       w_state_q;
  logic           awready_q, wready_q, bvalid_q, werr_q;
  logic [IDW-1:0] wid_q;
  logic [WA-1:0]  waddr_q;
  logic [7:0]     wlen_q, wcnt_q;
  logic [1:0]     wburst_q, bresp_q;

  r_state_e       r_state_q;
  logic           arready_q, rvalid_q, rlast_q;
  logic [IDW-1:0] rid_q;
  logic [WA-1:0]  raddr_q;
  logic [7:0]     rlen_q, rcnt_q;
  logic [1:0]     rburst_q, rresp_q;
  logic [DW-1:0]  rdata_q;

  logic          w_hs, w_cnt_last, w_beat_err, w_oob, w_mem_en;
  logic [WA-1:0] r_load_addr;
  logic          r_load_oob;
  logic [DW-1:0] r_load_data;
  logic [1:0]    r_load_resp;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    w_hs       = s00_axi_wvalid & wready_q;
    w_cnt_last = (wcnt_q == wlen_q);
    w_beat_err = s00_axi_wlast ^ w_cnt_last;
    r_load_addr = (r_state_q == R_IDLE) ? s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]
                                        : raddr_q + WA'(rburst_q != BURST_FIXED);
`ifdef AXI_SLV_RANGE_CHECK_EN
    w_oob      = |waddr_q[WA-1:IW];
    r_load_oob = |r_load_addr[WA-1:IW];
`else
    w_oob      = 1'b0;
    r_load_oob = 1'b0;
`endif
    w_mem_en    = s00_axi_aresetn & (w_state_q == W_DATA) & w_hs & ~w_oob;
    r_load_data = r_load_oob ? '0 : mem_q[r_load_addr[IW-1:0]];
    r_load_resp = r_load_oob ? RESP_SLVERR : RESP_OKAY;
  end

  // NOTE: the array has no reset; its contents are defined only by writes and survive reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_mem_en) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (s00_axi_wstrb[b]) mem_q[waddr_q[IW-1:0]][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      werr_q    <= 1'b0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wburst_q  <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (s00_axi_awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wid_q     <= s00_axi_awid;
            waddr_q   <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            wlen_q    <= s00_axi_awlen;
            wburst_q  <= s00_axi_awburst;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr_q <= waddr_q + WA'(wburst_q != BURST_FIXED);
            wcnt_q  <= wcnt_q + 8'd1;
            // Whichever of wlast or the beat count comes first closes the burst.
            if (s00_axi_wlast || w_cnt_last) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (werr_q | w_beat_err | w_oob) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end else begin
              werr_q <= werr_q | w_beat_err | w_oob;
            end
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rburst_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (s00_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= s00_axi_arid;
            raddr_q   <= r_load_addr;
            rlen_q    <= s00_axi_arlen;
            rburst_q  <= s00_axi_arburst;
            rcnt_q    <= '0;
            rdata_q   <= r_load_data;
            rresp_q   <= r_load_resp;
            rlast_q   <= (s00_axi_arlen == 8'd0);
            rvalid_q  <= 1'b1;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              // Next word is fetched on the accepting edge, keeping beats back-to-back.
              raddr_q <= r_load_addr;
              rcnt_q  <= rcnt_q + 8'd1;
              rdata_q <= r_load_data;
              rresp_q <= r_load_resp;
              rlast_q <= (rcnt_q + 8'd1 == rlen_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0], r_load_addr[WA-1:IW]};

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bid     = wid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rid     = rid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rlast   = rlast_q;
  assign s00_axi_rvalid  = rvalid_q;
endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Directed bench for axi_burst_slave_mem: bursts, strobes, FIXED, back-pressure, wlast errors, wrap.
module tb_axi_burst_slave_mem;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_burst_slave_mem dut (
    .s00_axi_aclk(clk),       .s00_axi_aresetn(aresetn),
    .s00_axi_awid(awid),      .s00_axi_awaddr(awaddr),   .s00_axi_awlen(awlen),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),     .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
    .s00_axi_bid(bid),        .s00_axi_bresp(bresp),     .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_arid(arid),      .s00_axi_araddr(araddr),   .s00_axi_arlen(arlen),
    .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid),        .s00_axi_rdata(rdata),     .s00_axi_rresp(rresp),
    .s00_axi_rlast(rlast),    .s00_axi_rvalid(rvalid),   .s00_axi_rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge; a handshake happens on the rising edge in between.
  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic id);
    int n = 0;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("aw_ready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    check("w_ready", 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic id, input logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_bid"}, 32'(bid), 32'(id));
    check({tag, "_bresp"}, 32'(bresp), 32'(resp));
    @(negedge clk);
    bready = 1'b0;
    check({tag, "_bdone"}, 32'(bvalid), 32'd0);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic id);
    int n = 0;
    araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check("ar_ready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check("r_latency", 32'(rvalid), 32'd1);
  endtask

  task automatic r_beat(input string tag, input logic [31:0] data, input logic last,
                        input logic [1:0] resp, input logic id);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, data);
    check({tag, "_rlast"}, 32'(rlast), 32'(last));
    check({tag, "_rresp"}, 32'(rresp), 32'(resp));
    check({tag, "_rid"}, 32'(rid), 32'(id));
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    aw_send(addr, 8'd0, 2'b01, 1'b0);
    w_beat(data, strb, 1'b1);
    b_check("w1", 1'b0, 2'b00);
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'({awready, arready}), 32'b11);
    check("rel_valid", 32'({bvalid, rvalid, wready}), 32'd0);

    // INCR burst of four words, echoed ID 1.
    aw_send(32'h40, 8'd3, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) w_beat(32'h1111_1111 * (i + 1), 4'hF, i == 3);
    b_check("incr", 1'b1, 2'b00);
    ar_send(32'h40, 8'd3, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) r_beat("incr_rd", 32'h1111_1111 * (i + 1), i == 3, 2'b00, 1'b1);
    check("incr_rd_end", 32'(rvalid), 32'd0);

    // Byte strobes 0101 clear bytes 0 and 2 only.
    write1(32'h10, 32'hAABB_CCDD, 4'hF);
    write1(32'h10, 32'h0000_0000, 4'b0101);
    ar_send(32'h10, 8'd0, 2'b01, 1'b0);
    r_beat("strb", 32'hAA00_CC00, 1'b1, 2'b00, 1'b0);

    // FIXED burst keeps hitting one word; the last beat wins.
    aw_send(32'h20, 8'd2, 2'b00, 1'b0);
    for (int i = 1; i <= 3; i++) w_beat(32'(i), 4'hF, i == 3);
    b_check("fixed", 1'b0, 2'b00);
    ar_send(32'h20, 8'd0, 2'b01, 1'b0);
    r_beat("fixed", 32'h0000_0003, 1'b1, 2'b00, 1'b0);

    // Eight-beat read with rready toggling: each beat must hold while stalled.
    aw_send(32'h200, 8'd7, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) w_beat(32'hC0DE_0000 + 32'(i), 4'hF, i == 7);
    b_check("bp_wr", 1'b0, 2'b00);
    ar_send(32'h200, 8'd7, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rready = 1'b0;
      @(negedge clk);
      check("bp_hold_valid", 32'(rvalid), 32'd1);
      check("bp_hold_data", rdata, 32'hC0DE_0000 + 32'(i));
      check("bp_hold_last", 32'(rlast), 32'(i == 7));
      r_beat("bp", 32'hC0DE_0000 + 32'(i), i == 7, 2'b00, 1'b1);
    end
    check("bp_end", 32'(rvalid), 32'd0);

    // Early wlast on the second beat of a len-3 burst.
    aw_send(32'h60, 8'd3, 2'b01, 1'b0);
    w_beat(32'hE000_0000, 4'hF, 1'b0);
    w_beat(32'hE111_1111, 4'hF, 1'b1);
    check("early_wready", 32'(wready), 32'd0);
    b_check("early", 1'b0, 2'b10);
    write1(32'h60, 32'h7777_7777, 4'hF);
    // Count reaching len without wlast is also an error, but the data still lands.
    aw_send(32'h68, 8'd0, 2'b01, 1'b1);
    w_beat(32'h8888_8888, 4'hF, 1'b0);
    b_check("nolast", 1'b1, 2'b10);
    ar_send(32'h60, 8'd2, 2'b01, 1'b0);
    r_beat("err_rd0", 32'h7777_7777, 1'b0, 2'b00, 1'b0);
    r_beat("err_rd1", 32'hE111_1111, 1'b0, 2'b00, 1'b0);
    r_beat("err_rd2", 32'h8888_8888, 1'b1, 2'b00, 1'b0);

    // One word past the end of a 1024-word array.
    write1(32'h0, 32'h0123_4567, 4'hF);
    aw_send(32'h1000, 8'd0, 2'b01, 1'b1);
    w_beat(32'h5A5A_5A5A, 4'hF, 1'b1);
`ifdef AXI_SLV_RANGE_CHECK_EN
    b_check("oob_wr", 1'b1, 2'b10);
    ar_send(32'h0, 8'd0, 2'b01, 1'b0);
    r_beat("oob_w0", 32'h0123_4567, 1'b1, 2'b00, 1'b0);
    ar_send(32'h1000, 8'd0, 2'b01, 1'b1);
    r_beat("oob_rd", 32'h0000_0000, 1'b1, 2'b10, 1'b1);
`else
    b_check("wrap_wr", 1'b1, 2'b00);
    ar_send(32'h0, 8'd0, 2'b01, 1'b0);
    r_beat("wrap_w0", 32'h5A5A_5A5A, 1'b1, 2'b00, 1'b0);
    ar_send(32'h1000, 8'd0, 2'b01, 1'b1);
    r_beat("wrap_rd", 32'h5A5A_5A5A, 1'b1, 2'b00, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
